// File: rtl/byte_sus_pkg.sv
// Shared definitions for the n-lane byte striper and its future unstriper:
// default geometry, num_active width derivation and the active-lane clamp.
package byte_sus_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int NUM_LANES_DEF  = 4;
  localparam int FLUSH_IDLE_DEF = 2;

  function automatic int cnt_width(input int num_lanes);
    return $clog2(num_lanes) + 1;
  endfunction

  // A zero or oversized request means "use every physical lane".
  function automatic int clamp_active(input int num_active, input int num_lanes);
    if ((num_active == 0) || (num_active > num_lanes)) begin
      return num_lanes;
    end else begin
      return num_active;
    end
  endfunction

endpackage

// File: rtl/byte_stripe_gather.sv
// Gather side of the striper: slot buffer, fill index, latched group size
// and idle counter that requests a flush of a stalled partial group.
module byte_stripe_gather
  import byte_sus_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_LANES  = NUM_LANES_DEF,
  parameter int FLUSH_IDLE = FLUSH_IDLE_DEF,
  parameter int CNT_W      = cnt_width(NUM_LANES)
) (
  input  logic                          clk_f,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          accept,
  input  logic                          flush_take,
  input  logic [CNT_W-1:0]              num_active,
  output logic                          last_slot,
  output logic                          group_done,
  output logic                          flush_req,
  output logic [NUM_LANES*DATA_W-1:0]   gathered,
  output logic [NUM_LANES-1:0]          valid_mask
);

  localparam int IDX_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int IDLE_W = $clog2(FLUSH_IDLE + 1);

  logic [DATA_W-1:0] slot_r [NUM_LANES];
  logic [CNT_W-1:0]  idx_r;
  logic [CNT_W-1:0]  g_r;
  logic [CNT_W-1:0]  g_eff_s;
  logic [IDLE_W-1:0] idle_r;

  // Group size: live clamp of num_active at the group start, latched value mid-group.
  always_comb begin
    g_eff_s = g_r;
    if (idx_r == {CNT_W{1'b0}}) begin
      g_eff_s = CNT_W'(clamp_active(int'(num_active), NUM_LANES));
    end else begin
      g_eff_s = g_r;
    end
    last_slot  = (idx_r == (g_eff_s - CNT_W'(1)));
    group_done = accept && last_slot;
    flush_req  = (idle_r == IDLE_W'(FLUSH_IDLE));
  end

  // Assemble the candidate output: the incoming word sits at slot idx; unused lanes are zeroed.
  always_comb begin
    gathered   = {(NUM_LANES*DATA_W){1'b0}};
    valid_mask = {NUM_LANES{1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      valid_mask[i] = (CNT_W'(i) < idx_r) || (group_done && (CNT_W'(i) == idx_r));
      if (!valid_mask[i]) begin
        gathered[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else if (CNT_W'(i) == idx_r) begin
        gathered[i*DATA_W +: DATA_W] = data_in;
      end else begin
        gathered[i*DATA_W +: DATA_W] = slot_r[i];
      end
    end
  end

  // Fill index, group-size latch, slot buffer and idle counter.
  always_ff @(posedge clk_f) begin
    if (reset) begin
      idx_r  <= {CNT_W{1'b0}};
      g_r    <= CNT_W'(NUM_LANES);
      idle_r <= {IDLE_W{1'b0}};
      for (int i = 0; i < NUM_LANES; i++) begin
        slot_r[i] <= {DATA_W{1'b0}};
      end
    end else if (accept) begin
      slot_r[idx_r[IDX_W-1:0]] <= data_in;
      idx_r  <= group_done ? {CNT_W{1'b0}} : (idx_r + CNT_W'(1));
      if (idx_r == {CNT_W{1'b0}}) begin
        g_r <= g_eff_s;
      end
      idle_r <= {IDLE_W{1'b0}};
    end else if (flush_take) begin
      idx_r  <= {CNT_W{1'b0}};
      idle_r <= {IDLE_W{1'b0}};
    end else if (idx_r == {CNT_W{1'b0}}) begin
      idle_r <= {IDLE_W{1'b0}};
    end else if (idle_r != IDLE_W'(FLUSH_IDLE)) begin
      idle_r <= idle_r + IDLE_W'(1);
    end
  end

endmodule

// File: rtl/byte_striping_nlane.sv
// N-lane byte striper: round-robin gathers input words and presents each
// full (or idle-flushed partial) group on all lanes through one output register.
module byte_striping_nlane
  import byte_sus_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_LANES  = NUM_LANES_DEF,
  parameter int FLUSH_IDLE = FLUSH_IDLE_DEF,
  parameter int CNT_W      = cnt_width(NUM_LANES)
) (
  input  logic                          clk_f,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  input  logic [CNT_W-1:0]              num_active,
  output logic [NUM_LANES*DATA_W-1:0]   lane_data,
  output logic [NUM_LANES-1:0]          lane_valid,
  input  logic                          lanes_ready
);

  logic                        accept_s;
  logic                        out_free_s;
  logic                        flush_take_s;
  logic                        last_slot_s;
  logic                        group_done_s;
  logic                        flush_req_s;
  logic [NUM_LANES*DATA_W-1:0] gathered_s;
  logic [NUM_LANES-1:0]        valid_mask_s;

  byte_stripe_gather #(
    .DATA_W     (DATA_W),
    .NUM_LANES  (NUM_LANES),
    .FLUSH_IDLE (FLUSH_IDLE),
    .CNT_W      (CNT_W)
  ) u_gather (
    .clk_f      (clk_f),
    .reset      (reset),
    .data_in    (data_in),
    .accept     (accept_s),
    .flush_take (flush_take_s),
    .num_active (num_active),
    .last_slot  (last_slot_s),
    .group_done (group_done_s),
    .flush_req  (flush_req_s),
    .gathered   (gathered_s),
    .valid_mask (valid_mask_s)
  );

  // Handshake: only the closing word of a group can be back-pressured, and
  // only while the presented group is still waiting on lanes_ready.
  always_comb begin
    out_free_s   = (lane_valid == {NUM_LANES{1'b0}}) || lanes_ready;
    ready_out    = !reset && !(last_slot_s && !out_free_s);
    accept_s     = valid_in && ready_out;
    flush_take_s = flush_req_s && out_free_s && !accept_s;
  end

  // Output register: load a completed/flushed group, clear on consume, else hold.
  always_ff @(posedge clk_f) begin
    if (reset) begin
      lane_data  <= {(NUM_LANES*DATA_W){1'b0}};
      lane_valid <= {NUM_LANES{1'b0}};
    end else if (group_done_s || flush_take_s) begin
      lane_data  <= gathered_s;
      lane_valid <= valid_mask_s;
    end else if (lanes_ready) begin
      lane_data  <= {(NUM_LANES*DATA_W){1'b0}};
      lane_valid <= {NUM_LANES{1'b0}};
    end
  end

endmodule

// File: tb/tb_byte_striping_nlane.sv
// Directed self-checking bench for byte_striping_nlane (DATA_W=32, 4 lanes, FLUSH_IDLE=2).
module tb_byte_striping_nlane;

  logic         clk_f = 1'b0;
  logic         reset;
  logic [31:0]  data_in;
  logic         valid_in;
  logic         ready_out;
  logic [2:0]   num_active;
  logic [127:0] lane_data;
  logic [3:0]   lane_valid;
  logic         lanes_ready;

  int checks = 0;
  int errors = 0;

  byte_striping_nlane #(
    .DATA_W     (32),
    .NUM_LANES  (4),
    .FLUSH_IDLE (2),
    .CNT_W      (3)
  ) dut (
    .clk_f       (clk_f),
    .reset       (reset),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .num_active  (num_active),
    .lane_data   (lane_data),
    .lane_valid  (lane_valid),
    .lanes_ready (lanes_ready)
  );

  always #5 clk_f = ~clk_f;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_f);
    #1;
  endtask

  // Offer one word, check ready_out before the edge, then step past the edge.
  task automatic push(input logic [31:0] w, input logic exp_rdy);
    valid_in = 1'b1;
    data_in  = w;
    #1;
    chk("ready", {127'd0, ready_out}, {127'd0, exp_rdy});
    tick();
    valid_in = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [127:0] d, input logic [3:0] v);
    chk({tag, "_valid"}, {124'd0, lane_valid}, {124'd0, v});
    chk({tag, "_data"}, lane_data, d);
  endtask

  initial begin
    reset       = 1'b1;
    valid_in    = 1'b1;
    data_in     = 32'hDEAD_BEEF;
    num_active  = 3'd4;
    lanes_ready = 1'b1;

    // 1: reset held with valid_in high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready", {127'd0, ready_out}, 128'd0);
      chk_out("rst", 128'd0, 4'b0000);
    end
    reset    = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("rel_ready", {127'd0, ready_out}, 128'd1);

    // 2: full groups back-to-back
    push(32'h1, 1'b1); push(32'h2, 1'b1); push(32'h3, 1'b1);
    chk_out("pre_g1", 128'd0, 4'b0000);
    push(32'h4, 1'b1);
    chk_out("g1", {32'h4, 32'h3, 32'h2, 32'h1}, 4'b1111);
    push(32'h5, 1'b1);
    chk_out("g1_gone", 128'd0, 4'b0000);
    push(32'h6, 1'b1); push(32'h7, 1'b1); push(32'h8, 1'b1);
    chk_out("g2", {32'h8, 32'h7, 32'h6, 32'h5}, 4'b1111);
    tick();
    chk_out("g2_gone", 128'd0, 4'b0000);

    // 3: idle-timeout partial flush
    push(32'hA, 1'b1); push(32'hB, 1'b1); push(32'hC, 1'b1);
    tick();
    chk_out("idle1", 128'd0, 4'b0000);
    tick();
    chk_out("idle2", 128'd0, 4'b0000);
    tick();
    chk_out("flush3", {32'h0, 32'hC, 32'hB, 32'hA}, 4'b0111);
    push(32'hD, 1'b1); push(32'hE, 1'b1); push(32'hF, 1'b1); push(32'h10, 1'b1);
    chk_out("after_flush", {32'h10, 32'hF, 32'hE, 32'hD}, 4'b1111);

    // 4: back-pressure on the closing word
    push(32'h1, 1'b1); push(32'h2, 1'b1); push(32'h3, 1'b1); push(32'h4, 1'b1);
    chk_out("bp_g1", {32'h4, 32'h3, 32'h2, 32'h1}, 4'b1111);
    lanes_ready = 1'b0;
    push(32'h5, 1'b1); push(32'h6, 1'b1); push(32'h7, 1'b1);
    chk_out("bp_hold", {32'h4, 32'h3, 32'h2, 32'h1}, 4'b1111);
    push(32'h8, 1'b0);
    chk_out("bp_hold2", {32'h4, 32'h3, 32'h2, 32'h1}, 4'b1111);
    lanes_ready = 1'b1;
    push(32'h8, 1'b1);
    chk_out("bp_g2", {32'h8, 32'h7, 32'h6, 32'h5}, 4'b1111);
    tick();

    // 5: narrow link, clamp of 0 and out-of-range, x1, mid-group change ignored
    num_active = 3'd2;
    push(32'h1, 1'b1); push(32'h2, 1'b1);
    chk_out("x2_a", {32'h0, 32'h0, 32'h2, 32'h1}, 4'b0011);
    push(32'h3, 1'b1); push(32'h4, 1'b1);
    chk_out("x2_b", {32'h0, 32'h0, 32'h4, 32'h3}, 4'b0011);
    num_active = 3'd0;
    push(32'h1, 1'b1); push(32'h2, 1'b1); push(32'h3, 1'b1); push(32'h4, 1'b1);
    chk_out("x0", {32'h4, 32'h3, 32'h2, 32'h1}, 4'b1111);
    num_active = 3'd7;
    push(32'h21, 1'b1); push(32'h22, 1'b1); push(32'h23, 1'b1); push(32'h24, 1'b1);
    chk_out("x7", {32'h24, 32'h23, 32'h22, 32'h21}, 4'b1111);
    num_active = 3'd1;
    push(32'h99, 1'b1);
    chk_out("x1", {32'h0, 32'h0, 32'h0, 32'h99}, 4'b0001);
    num_active = 3'd4;
    push(32'h31, 1'b1);
    num_active = 3'd2;
    push(32'h32, 1'b1);
    chk_out("mid_chg", 128'd0, 4'b0000);
    push(32'h33, 1'b1); push(32'h34, 1'b1);
    chk_out("mid_full", {32'h34, 32'h33, 32'h32, 32'h31}, 4'b1111);
    num_active = 3'd4;
    tick();

    // 6: reset discards a partial group
    push(32'h1, 1'b1); push(32'h2, 1'b1);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("no_flush", 128'd0, 4'b0000);
    end
    push(32'h55, 1'b1);
    tick(); tick(); tick();
    chk_out("new_grp", {32'h0, 32'h0, 32'h0, 32'h55}, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
